pow_n_pipe_hs: RTL

- Parametrised successor of the fixed pow-5 pipelined power unit: computes res = n^POW modulo 2^RW over POW-1 multiply stages.
- Adds per-stage valid/ready flow control with bubble collapsing, so the pipeline holds data under downstream backpressure.
- Adds a sticky per-item overflow flag that travels with each result.
- Sits between switch/key input logic and the 7-segment display driver. Per-stage valids drive display digit enables.

---
 rtl/pow_n_pipe_hs_if.sv | 33 +++
 rtl/pow_n_pipe_hs.sv | 74 +++++++
 2 files changed

// File: rtl/pow_n_pipe_hs_if.sv
// ============================================================================
// Module      : pow_n_pipe_hs_if
// Description : Operand/result handshake bundle for the pow_n_pipe_hs unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pow_n_pipe_hs_if #(
    parameter int W   = 8,
    parameter int POW = 5,
    parameter int RW  = 32
) ();
    logic           n_vld;
    logic           n_rdy;
    logic [W-1:0]   n;
    logic           res_vld;
    logic           res_rdy;
    logic [RW-1:0]  res;
    logic           res_ovf;
    logic [POW-2:0] stage_vld;

    modport master (
        output n_vld, n, res_rdy,
        input  n_rdy, res_vld, res, res_ovf, stage_vld
    );

    modport slave (
        input  n_vld, n, res_rdy,
        output n_rdy, res_vld, res, res_ovf, stage_vld
    );
endinterface

`default_nettype wire

// File: rtl/pow_n_pipe_hs.sv
// ============================================================================
// Module      : pow_n_pipe_hs
// Description : n^POW mod 2^RW over POW-1 elastic multiply stages with sticky
//               overflow and bubble-collapsing valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pow_n_pipe_hs #(
    parameter int W   = 8,
    parameter int POW = 5,
    parameter int RW  = 32
) (
    input  logic             clk,
    input  logic             rst,
    pow_n_pipe_hs_if.slave   bus
);
    localparam int c_NS = POW - 1;
    localparam int c_PW = 2 * RW;

    logic [c_NS-1:0] r_vld;
    logic [c_NS-1:0] r_o;
    logic [W-1:0]    r_a [c_NS];
    logic [RW-1:0]   r_p [c_NS];
    logic [c_NS-1:0] w_rdy;
    logic [c_NS-1:0] w_up_vld;

    for (genvar i = 0; i < c_NS; i++) begin : g_stage
        logic [c_PW-1:0] w_prod;
        logic [W-1:0]    w_a_in;
        logic            w_o_in;

        // A stage can move unless it and every stage after it are full and
        // the sink is stalling; this is the ready chain unrolled.
        assign w_rdy[i] = bus.res_rdy | ~(&r_vld[c_NS-1:i]);

        if (i == 0) begin : g_first
            assign w_up_vld[i] = bus.n_vld;
            assign w_a_in      = bus.n;
            assign w_o_in      = 1'b0;
            assign w_prod      = {{(c_PW-W){1'b0}}, bus.n} * {{(c_PW-W){1'b0}}, bus.n};
        end else begin : g_rest
            assign w_up_vld[i] = r_vld[i-1];
            assign w_a_in      = r_a[i-1];
            assign w_o_in      = r_o[i-1];
            assign w_prod      = {{RW{1'b0}}, r_p[i-1]} * {{(c_PW-W){1'b0}}, r_a[i-1]};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld[i] <= 1'b0;
                r_a[i]   <= '0;
                r_p[i]   <= '0;
                r_o[i]   <= 1'b0;
            end else if (w_rdy[i]) begin
                r_vld[i] <= w_up_vld[i];
                if (w_up_vld[i]) begin
                    r_a[i] <= w_a_in;
                    r_p[i] <= w_prod[RW-1:0];
                    r_o[i] <= w_o_in | (|w_prod[c_PW-1:RW]);
                end
            end
        end
    end

    assign bus.n_rdy     = w_rdy[0];
    assign bus.res_vld   = r_vld[c_NS-1];
    assign bus.res       = r_p[c_NS-1];
    assign bus.res_ovf   = r_o[c_NS-1];
    assign bus.stage_vld = r_vld;

endmodule

`default_nettype wire
